// File: rtl/fp_compare_pipe.sv
// Two-stage, multi-lane IEEE-style floating-point comparator with valid/ready flow control.
// Stage 1 decodes each lane to sign, class and magnitude relation. Stage 2 resolves the requested relation and a popcount.

module fp_cmp_lane #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic [2:0]               mode,
  output logic                     res,
  output logic                     unord
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] MODE_LT = 3'd0;
  localparam logic [2:0] MODE_LE = 3'd1;
  localparam logic [2:0] MODE_EQ = 3'd2;
  localparam logic [2:0] MODE_GE = 3'd3;
  localparam logic [2:0] MODE_GT = 3'd4;
  localparam logic [2:0] MODE_NE = 3'd5;

  logic sign_a_d, sign_b_d, nan_a_d, nan_b_d, zero_a_d, zero_b_d, mag_gt_d, mag_eq_d;
  logic sign_a_q, sign_b_q, nan_a_q, nan_b_q, zero_a_q, zero_b_q, mag_gt_q, mag_eq_q;

  // exp||mantissa ordered as an unsigned integer gives the magnitude order
  always_comb begin
    sign_a_d = a[W-1];
    sign_b_d = b[W-1];
    nan_a_d  = (&a[W-2 -: EXP_W]) && (|a[MAN_W-1:0]);
    nan_b_d  = (&b[W-2 -: EXP_W]) && (|b[MAN_W-1:0]);
    zero_a_d = ~|a[W-2:0];
    zero_b_d = ~|b[W-2:0];
    mag_gt_d = a[W-2:0] > b[W-2:0];
    mag_eq_d = a[W-2:0] == b[W-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      nan_a_q  <= 1'b0;
      nan_b_q  <= 1'b0;
      zero_a_q <= 1'b0;
      zero_b_q <= 1'b0;
      mag_gt_q <= 1'b0;
      mag_eq_q <= 1'b0;
    end else if (ld) begin
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      nan_a_q  <= nan_a_d;
      nan_b_q  <= nan_b_d;
      zero_a_q <= zero_a_d;
      zero_b_q <= zero_b_d;
      mag_gt_q <= mag_gt_d;
      mag_eq_q <= mag_eq_d;
    end
  end

  logic eq, lt, gt;

  always_comb begin
    eq = (zero_a_q && zero_b_q) || ((sign_a_q == sign_b_q) && mag_eq_q);
    if (zero_a_q && zero_b_q)
      lt = 1'b0;
    else if (sign_a_q != sign_b_q)
      lt = sign_a_q;
    else if (sign_a_q)
      lt = mag_gt_q;
    else
      lt = !mag_gt_q && !mag_eq_q;
    gt    = !lt && !eq;
    unord = nan_a_q || nan_b_q;
    res   = 1'b0;
    if (unord)
      res = (mode == MODE_NE);
    else begin
      case (mode)
        MODE_LT: res = lt;
        MODE_LE: res = lt || eq;
        MODE_EQ: res = eq;
        MODE_GE: res = gt || eq;
        MODE_GT: res = gt;
        MODE_NE: res = !eq;
        default: res = 1'b0;
      endcase
    end
  end
endmodule

module fp_compare_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LANES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0]                       in_mode,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_a,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0]                 out_res,
  output logic [LANES-1:0]                 out_unord,
  output logic [$clog2(LANES+1)-1:0]       out_count
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int CNT_W = $clog2(LANES+1);

  logic [2:1]       vld_pipe_d, vld_pipe_q;
  logic [2:0]       mode_d, mode_q;
  logic             adv1, adv2, accept, ld2;
  logic [LANES-1:0] res_c, unord_c;

  logic [LANES-1:0] out_res_d, out_res_q, out_unord_d, out_unord_q;
  logic [CNT_W-1:0] out_count_d, out_count_q;

  // in_ready looks through both stages so a draining pipe accepts without a bubble
  always_comb begin
    adv2       = !vld_pipe_q[2] || out_ready;
    adv1       = !vld_pipe_q[1] || adv2;
    accept     = in_valid && adv1;
    ld2        = adv2 && vld_pipe_q[1];
    vld_pipe_d = vld_pipe_q;
    if (adv2) vld_pipe_d[2] = vld_pipe_q[1];
    if (adv1) vld_pipe_d[1] = in_valid;
    mode_d     = accept ? in_mode : mode_q;
  end

  assign in_ready = adv1;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_cmp_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .ld    (accept),
      .a     (in_a[i*W +: W]),
      .b     (in_b[i*W +: W]),
      .mode  (mode_q),
      .res   (res_c[i]),
      .unord (unord_c[i])
    );
  end

  always_comb begin
    out_res_d   = out_res_q;
    out_unord_d = out_unord_q;
    out_count_d = out_count_q;
    if (ld2) begin
      out_res_d   = res_c;
      out_unord_d = unord_c;
      out_count_d = '0;
      for (int i = 0; i < LANES; i++)
        out_count_d = out_count_d + CNT_W'(res_c[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      mode_q      <= '0;
      out_res_q   <= '0;
      out_unord_q <= '0;
      out_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      mode_q      <= mode_d;
      out_res_q   <= out_res_d;
      out_unord_q <= out_unord_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_res   = out_res_q;
  assign out_unord = out_unord_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed checks for fp_compare_pipe: relations, NaN handling, backpressure, mid-flight reset.
module tb_fp_compare_pipe;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   in_mode;
  logic [127:0] in_a, in_b;
  logic [3:0]   out_res, out_unord;
  logic [2:0]   out_count;

  int total = 0;
  int bad   = 0;

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_unord(out_unord), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // offer one beat, then check latency and result
  task automatic vec(input string tag, input logic [2:0] m, input logic [127:0] a,
                     input logic [127:0] b, input logic [3:0] er, input logic [3:0] eu,
                     input logic [2:0] ec);
    chk({tag, "_rdy"}, in_ready, 1);
    in_mode = m; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, out_res, er);
    chk({tag, "_unord"}, out_unord, eu);
    chk({tag, "_cnt"}, out_count, ec);
  endtask

  // backpressure scoreboard
  logic [3:0] exp_q[$];
  bit         mon_en = 0;
  int         n_pop  = 0;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("bp_extra", 1, 0);
      else begin
        chk("bp_res", out_res, exp_q.pop_front());
        n_pop++;
      end
    end
  end

  function automatic logic [127:0] lt_pat(input logic [3:0] p);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = p[i] ? 32'h0000_0000 : 32'h4000_0000;
    return v;
  endfunction

  logic [3:0] pats[4];

  initial begin
    pats[0] = 4'b0001; pats[1] = 4'b0010; pats[2] = 4'b0100; pats[3] = 4'b1000;
    rst = 1'b1; in_valid = 0; in_mode = 0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    chk("rst_vld", out_valid, 0);
    chk("rst_res", out_res, 0);
    chk("rst_unord", out_unord, 0);
    chk("rst_cnt", out_count, 0);
    @(posedge clk); #1; rst = 1'b0;
    #1 chk("rst_inrdy", in_ready, 1);

    vec("lt", 3'd0, {32'h7F800000, 32'h00000000, 32'hBF800000, 32'h3F800000},
                    {32'h7F800000, 32'h80000000, 32'h3F800000, 32'h40000000}, 4'b0011, 4'b0000, 3'd2);
    vec("eq", 3'd2, {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000},
                    {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h80000000}, 4'b1111, 4'b0000, 3'd4);
    for (int m = 0; m < 6; m++) begin
      logic [3:0] er; logic [2:0] ec;
      case (m)
        0, 1:    begin er = 4'b1011; ec = 3'd3; end
        5:       begin er = 4'b1111; ec = 3'd4; end
        default: begin er = 4'b0000; ec = 3'd0; end
      endcase
      vec($sformatf("nan_m%0d", m), 3'(m),
          {32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'h3F800000},
          {4{32'h40000000}}, er, 4'b0100, ec);
    end
    vec("rsv6", 3'd6, {32'h7F800000, 32'h00000000, 32'hBF800000, 32'h3F800000},
                      {32'h7F800000, 32'h80000000, 32'h3F800000, 32'h40000000}, 4'b0000, 4'b0000, 3'd0);
    vec("rsv7_nan", 3'd7, {32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'h3F800000},
                          {4{32'h40000000}}, 4'b0000, 4'b0100, 3'd0);
    vec("ge_neg", 3'd3, {4{32'hC0000000}}, {4{32'hBF800000}}, 4'b0000, 4'b0000, 3'd0);
    vec("gt_neg", 3'd4, {4{32'hBF800000}}, {4{32'hC0000000}}, 4'b1111, 4'b0000, 3'd4);
    vec("gt_den", 3'd4, {32'hFF800000, 32'h00000001, 32'h7F800000, 32'h00000001},
                        {32'h7F800000, 32'h80000000, 32'h7F7FFFFF, 32'h00000000}, 4'b0111, 4'b0000, 3'd3);
    @(posedge clk); #1;

    // backpressure: 4 back-to-back beats, stall 3 cycles after first result
    mon_en = 1;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          int guard;
          in_mode = 3'd0; in_a = lt_pat(pats[k]); in_b = {4{32'h3F800000}}; in_valid = 1'b1;
          guard = 0;
          @(negedge clk);
          while (!in_ready && guard < 50) begin guard++; @(negedge clk); end
          if (guard >= 50) chk("bp_accept_timeout", 1, 0);
          exp_q.push_back(pats[k]);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int guard = 0;
        @(posedge clk); #1;
        while (!out_valid && guard < 50) begin guard++; @(posedge clk); #1; end
        out_ready = 1'b0;
        #1 chk("bp_inrdy_low", in_ready, 0);
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("bp_hold_vld", out_valid, 1);
          chk("bp_hold_res", out_res, pats[0]);
          chk("bp_hold_cnt", out_count, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    begin
      int guard = 0;
      while (n_pop < 4 && guard < 50) begin guard++; @(posedge clk); end
    end
    repeat (3) @(posedge clk);
    chk("bp_npop", n_pop, 4);
    chk("bp_qempty", exp_q.size(), 0);
    mon_en = 0;
    #1;

    // reset with two beats in flight
    in_mode = 3'd5; in_a = {4{32'h3F800000}}; in_b = {4{32'h40000000}}; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_res", out_res, 0);
    chk("mrst_cnt", out_count, 0);
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mrst_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    vec("post_rst", 3'd1, {4{32'h3F800000}}, {32'h00000000, 32'hBF800000, 32'h3F800000, 32'h40000000},
        4'b0011, 4'b0000, 3'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_compare_pipe.md
FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter LANES, default 4, number of parallel comparison lanes (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  input beat offered.
REQ-007 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port in_mode  input  3  relation: 0 LT, 1 LE, 2 EQ, 3 GE, 4 GT, 5 NE, 6-7 reserved.
REQ-009 SHALL have port in_a  input  LANES*W  operand A, lane i at bits [i*W +: W].
REQ-010 SHALL have port in_b  input  LANES*W  operand B, same packing.
REQ-011 SHALL have port out_valid  output  1  result beat available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_res  output  LANES  per-lane relation result (A rel B).
REQ-014 SHALL have port out_unord  output  LANES  per-lane unordered flag (either operand NaN).
REQ-015 SHALL have port out_count  output  $clog2(LANES+1)  number of set out_res bits.

Function
REQ-016 SHALL accept a beat when in_valid and in_ready are both high; in_mode is captured with the beat.
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers per-lane sign, NaN flags, zero flags, magnitude-greater and magnitude-equal; stage 2 registers out_res, out_unord, out_count.
REQ-018 SHALL present a result exactly 2 cycles after acceptance when out_ready is held high.
REQ-019 SHALL advance stage 2 when stage 2 is empty or out_ready is high; stage 1 advances when stage 1 is empty or stage 2 advances; in_ready = stage-1 empty or stage 1 advancing (combinational, no bubble).
REQ-020 SHALL hold out_valid, out_res, out_unord, out_count stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain one beat per cycle throughput with out_ready held high.
REQ-022 SHALL compare by sign and magnitude bits (exp||mantissa as unsigned), with no subtractor; denormals and infinities order naturally.
REQ-023 SHALL treat +0 and -0 as equal.
REQ-024 SHALL, for negative operands of the same sign, invert magnitude order.
REQ-025 SHALL flag NaN when exponent all ones and mantissa nonzero; if either operand is NaN, out_unord=1 and out_res=1 only for NE, 0 for all other modes.
REQ-026 SHALL output out_res=0 for reserved modes 6 and 7, out_unord still computed.
REQ-027 SHALL compute out_count as the popcount of the stage-2 out_res value, registered with it.
REQ-028 SHALL evaluate lanes independently; a NaN in one lane does not affect others.

Reset
REQ-029 SHALL on rst=1 immediately clear both stage valid bits; out_valid=0, out_res=0, out_unord=0, out_count=0.
REQ-030 SHALL drive in_ready=1 while rst=0 after reset (pipeline empty).
REQ-031 SHALL discard any in-flight beats when reset is asserted mid-operation; no result emerges after reset release without a new accepted beat.

Verification (W=32, LANES=4)
REQ-032 SHALL cover: mode LT, A lanes {3F800000,BF800000,00000000,7F800000}, B lanes {40000000,3F800000,80000000,7F800000} -> 2 cycles later out_res=4'b0011, out_unord=0, out_count=2.
REQ-033 SHALL cover: mode EQ, A lane0=00000000, B lane0=80000000, lanes1-3 equal 3F800000 -> out_res=4'b1111, out_count=4.
REQ-034 SHALL cover: A lane2=7FC00000, all modes 0-5 in sequence -> lane2 out_unord=1, out_res[2]=1 only for NE.
REQ-035 SHALL cover: 4 back-to-back beats, out_ready=0 for 3 cycles after first result -> in_ready drops once both stages full, results delivered in order with no loss or duplication.
REQ-036 SHALL cover: rst asserted with 2 beats in flight -> out_valid=0 same cycle, no results after release until new beat accepted.
REQ-037 SHALL cover: mode 6 with any operands -> out_res=0, out_count=0; mode GE with A=C0000000, B=BF800000 -> lane result 0.
